// File: rtl/trc_pkg.sv
// Shared trace-fetch definitions: line geometry, address width and the fetch state type.
// Imported by the trace cache and by trace_fetch_seq so both agree on line layout.
package trc_pkg;

    localparam int NRETIRE     = 8;
    localparam int VA_SZ       = 48;
    // Integer (non-FP) bundle layout, identical to the trace cache's bundle packing
    localparam int BUNDLE_SIZE = 175;

    typedef enum logic {
        RUN  = 1'b0,
        MISS = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/trace_fetch_seq_if.sv
// Fetch-side bus of trace_fetch_seq: trace cache lookup, fallback miss path, rename output, redirect.
// master = the fetch sequencer, slave = its environment (trace cache, I-cache path, rename, flush source).
interface trace_fetch_seq_if #(
    parameter int NRETIRE     = trc_pkg::NRETIRE,
    parameter int VA_SZ       = trc_pkg::VA_SZ,
    parameter int BUNDLE_SIZE = trc_pkg::BUNDLE_SIZE
);
    logic                            flush;
    logic [VA_SZ-1:1]                flush_pc;

    logic [VA_SZ-1:1]                tc_pc;
    logic                            tc_pc_used;
    logic                            tc_hit;
    logic [NRETIRE-1:0]              tc_valid;
    logic [NRETIRE*BUNDLE_SIZE-1:0]  tc_bundles;
    logic [VA_SZ-1:1]                tc_pc_next;

    logic                            miss_req;
    logic [VA_SZ-1:1]                miss_pc;
    logic                            miss_ack;
    logic [VA_SZ-1:1]                miss_next_pc;

    logic                            out_valid;
    logic                            out_ready;
    logic [NRETIRE-1:0]              out_mask;
    logic [NRETIRE*BUNDLE_SIZE-1:0]  out_data;
    logic [VA_SZ-1:1]                out_pc;

    modport master (
        input  flush, flush_pc,
        input  tc_hit, tc_valid, tc_bundles, tc_pc_next,
        input  miss_ack, miss_next_pc,
        input  out_ready,
        output tc_pc, tc_pc_used,
        output miss_req, miss_pc,
        output out_valid, out_mask, out_data, out_pc
    );

    modport slave (
        output flush, flush_pc,
        output tc_hit, tc_valid, tc_bundles, tc_pc_next,
        output miss_ack, miss_next_pc,
        output out_ready,
        input  tc_pc, tc_pc_used,
        input  miss_req, miss_pc,
        input  out_valid, out_mask, out_data, out_pc
    );

endinterface

// File: rtl/trace_fetch_fifo.sv
// Power-of-two depth FIFO with synchronous clear; head entry is always visible on rdata.
// Pushes while full and pops while empty are dropped.
module trace_fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Clear wins over any same-cycle push/pop; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/trace_fetch_seq.sv
// Fetch sequencer: owns the fetch PC, consumes trace cache hits into a line FIFO toward rename,
// and hands misses to the I-cache/decode fallback path.
module trace_fetch_seq
    import trc_pkg::*;
#(
    parameter int               NRETIRE     = trc_pkg::NRETIRE,
    parameter int               VA_SZ       = trc_pkg::VA_SZ,
    parameter int               BUNDLE_SIZE = trc_pkg::BUNDLE_SIZE,
    parameter int               QDEPTH      = 4,
    parameter logic [VA_SZ-1:1] RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              reset,
    trace_fetch_seq_if.master bus
);

    localparam int DATA_W = NRETIRE * BUNDLE_SIZE;
    localparam int LINE_W = NRETIRE + DATA_W + (VA_SZ - 1);
    localparam int CW     = $clog2(QDEPTH) + 1;

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [VA_SZ-1:1] r_pc;
    logic [VA_SZ-1:1] pc_next;
    logic             pc_used;
    logic             full;
    logic [CW-1:0]    count;
    logic [LINE_W-1:0] head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            r_pc  <= RESET_PC;
        end else begin
            state <= state_next;
            r_pc  <= pc_next;
        end
    end

    // Flush overrides everything; tc_pc_used is held low while reset is asserted
    always_comb begin
        state_next = state;
        pc_next    = r_pc;
        pc_used    = 1'b0;
        if (reset) begin
            if (bus.flush) begin
                state_next = RUN;
                pc_next    = bus.flush_pc;
            end else begin
                case (state)
                    RUN: begin
                        if (!bus.tc_hit) begin
                            state_next = MISS;
                        end else if (!full) begin
                            pc_used = 1'b1;
                            pc_next = bus.tc_pc_next;
                        end
                    end
                    MISS: begin
                        if (bus.miss_ack) begin
                            state_next = RUN;
                            pc_next    = bus.miss_next_pc;
                        end
                    end
                    default: state_next = RUN;
                endcase
            end
        end
    end

    trace_fetch_fifo #(
        .WIDTH (LINE_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (bus.flush),
        .push  (pc_used),
        .pop   (bus.out_valid && bus.out_ready),
        .wdata ({bus.tc_valid, bus.tc_bundles, r_pc}),
        .rdata (head),
        .count (count),
        .full  (full)
    );

    assign bus.tc_pc      = r_pc;
    assign bus.tc_pc_used = pc_used;
    assign bus.miss_req   = (state == MISS);
    assign bus.miss_pc    = r_pc;
    assign bus.out_valid  = (count != '0);
    assign bus.out_pc     = head[VA_SZ-2:0];
    assign bus.out_data   = head[DATA_W+VA_SZ-2:VA_SZ-1];
    assign bus.out_mask   = head[LINE_W-1:DATA_W+VA_SZ-1];

endmodule

// File: tb/tb_trace_fetch_seq.sv
// Directed self-checking bench for trace_fetch_seq: reset, hit latency, full back-pressure,
// miss handshake, flush redirect, wrap-around streaming and asynchronous reset.
module tb_trace_fetch_seq;
    import trc_pkg::*;

    localparam int PCW    = VA_SZ - 1;
    localparam int DATA_W = NRETIRE * BUNDLE_SIZE;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    trace_fetch_seq_if bus ();

    trace_fetch_seq #(
        .QDEPTH   (4),
        .RESET_PC ('0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DATA_W-1:0] mkdata(input int k);
        logic [DATA_W-1:0] d;
        d = '0;
        d[31:0] = 32'(k);
        d[DATA_W-1 -: 16] = 16'hA5A5 ^ 16'(k);
        return d;
    endfunction

    function automatic logic [NRETIRE-1:0] mkmask(input int k);
        logic [NRETIRE-1:0] m;
        m = '1;
        return m >> (k % NRETIRE);
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_flush(input logic [VA_SZ-1:1] pc);
        step();
        bus.flush    = 1'b1;
        bus.flush_pc = pc;
        bus.tc_hit   = 1'b0;
        bus.miss_ack = 1'b0;
        step();
        bus.flush    = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.tc_pc_used !== 1'b0) begin failures++; $display("[TB] FAIL reset_pc_used got %b want 0", bus.tc_pc_used); end
        checks++; if (bus.miss_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_miss_req got %b want 0", bus.miss_req); end
        checks++; if (bus.tc_pc !== PCW'(0)) begin failures++; $display("[TB] FAIL reset_tc_pc got %h want 0", bus.tc_pc); end
        step();
        step();
    endtask

    task automatic test_first_hit();
        reset          = 1'b1;
        bus.tc_hit     = 1'b1;
        bus.tc_pc_next = PCW'('h100);
        bus.tc_valid   = 8'hFF;
        bus.tc_bundles = mkdata(7);
        bus.out_ready  = 1'b1;
        #1;
        checks++; if (bus.tc_pc_used !== 1'b1) begin failures++; $display("[TB] FAIL first_pc_used got %b want 1", bus.tc_pc_used); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL first_valid_c0 got %b want 0", bus.out_valid); end
        step();
        bus.tc_hit = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL first_valid_c1 got %b want 1", bus.out_valid); end
        checks++; if (bus.out_pc !== PCW'(0)) begin failures++; $display("[TB] FAIL first_out_pc got %h want 0", bus.out_pc); end
        checks++; if (bus.tc_pc !== PCW'('h100)) begin failures++; $display("[TB] FAIL first_tc_pc got %h want 100", bus.tc_pc); end
        checks++; if (bus.out_data[31:0] !== 32'd7) begin failures++; $display("[TB] FAIL first_out_data got %h want 7", bus.out_data[31:0]); end
        do_flush(PCW'('h300));
    endtask

    task automatic test_full();
        logic [VA_SZ-1:1] exp_pc;
        int pulses;
        exp_pc = PCW'('h300);
        pulses = 0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.tc_hit     = 1'b1;
            bus.tc_pc_next = exp_pc + PCW'('h10);
            #1;
            checks++; if (bus.tc_pc !== exp_pc) begin failures++; $display("[TB] FAIL full_tc_pc[%0d] got %h want %h", i, bus.tc_pc, exp_pc); end
            checks++; if (bus.tc_pc_used !== (i < 4)) begin failures++; $display("[TB] FAIL full_pc_used[%0d] got %b want %b", i, bus.tc_pc_used, (i < 4)); end
            if (bus.tc_pc_used === 1'b1) pulses++;
            if (i < 4) exp_pc = exp_pc + PCW'('h10);
            step();
        end
        checks++; if (pulses != 4) begin failures++; $display("[TB] FAIL full_pulses got %0d want 4", pulses); end
        bus.out_ready  = 1'b1;
        bus.tc_pc_next = PCW'('h350);
        #1;
        checks++; if (bus.tc_pc_used !== 1'b0) begin failures++; $display("[TB] FAIL full_pop_cycle_used got %b want 0", bus.tc_pc_used); end
        checks++; if (bus.out_pc !== PCW'('h300)) begin failures++; $display("[TB] FAIL full_drain0 got %h want 300", bus.out_pc); end
        step();
        #1;
        checks++; if (bus.tc_pc_used !== 1'b1) begin failures++; $display("[TB] FAIL full_resume_used got %b want 1", bus.tc_pc_used); end
        checks++; if (bus.out_pc !== PCW'('h310)) begin failures++; $display("[TB] FAIL full_drain1 got %h want 310", bus.out_pc); end
        step();
        bus.tc_hit = 1'b0;
        for (int i = 2; i < 5; i++) begin
            #1;
            checks++; if (bus.out_pc !== PCW'('h300 + 'h10 * i)) begin failures++; $display("[TB] FAIL full_drain%0d got %h want %h", i, bus.out_pc, PCW'('h300 + 'h10 * i)); end
            step();
        end
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL full_empty got %b want 0", bus.out_valid); end
        do_flush(PCW'('h200));
    endtask

    task automatic test_miss();
        bus.tc_hit = 1'b0;
        #1;
        checks++; if (bus.tc_pc !== PCW'('h200)) begin failures++; $display("[TB] FAIL miss_tc_pc got %h want 200", bus.tc_pc); end
        checks++; if (bus.miss_req !== 1'b0) begin failures++; $display("[TB] FAIL miss_req_early got %b want 0", bus.miss_req); end
        step();
        #1;
        checks++; if (bus.miss_req !== 1'b1) begin failures++; $display("[TB] FAIL miss_req_set got %b want 1", bus.miss_req); end
        checks++; if (bus.miss_pc !== PCW'('h200)) begin failures++; $display("[TB] FAIL miss_pc got %h want 200", bus.miss_pc); end
        step();
        #1;
        checks++; if (bus.miss_req !== 1'b1) begin failures++; $display("[TB] FAIL miss_req_hold got %b want 1", bus.miss_req); end
        step();
        bus.miss_ack     = 1'b1;
        bus.miss_next_pc = PCW'('h240);
        #1;
        checks++; if (bus.miss_req !== 1'b1) begin failures++; $display("[TB] FAIL miss_req_ack_cycle got %b want 1", bus.miss_req); end
        step();
        bus.miss_ack   = 1'b0;
        bus.tc_hit     = 1'b1;
        bus.tc_pc_next = PCW'('h280);
        bus.out_ready  = 1'b1;
        #1;
        checks++; if (bus.miss_req !== 1'b0) begin failures++; $display("[TB] FAIL miss_req_clear got %b want 0", bus.miss_req); end
        checks++; if (bus.tc_pc !== PCW'('h240)) begin failures++; $display("[TB] FAIL miss_resume_pc got %h want 240", bus.tc_pc); end
        checks++; if (bus.tc_pc_used !== 1'b1) begin failures++; $display("[TB] FAIL miss_resume_run got %b want 1", bus.tc_pc_used); end
        step();
        bus.tc_hit = 1'b0;
        do_flush(PCW'('h500));
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.tc_hit     = 1'b1;
            bus.tc_pc_next = PCW'('h510 + 'h10 * i);
            step();
        end
        bus.tc_hit = 1'b0;
        step();
        #1;
        checks++; if (bus.miss_req !== 1'b1) begin failures++; $display("[TB] FAIL flush_pre_miss got %b want 1", bus.miss_req); end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL flush_pre_valid got %b want 1", bus.out_valid); end
        bus.flush    = 1'b1;
        bus.flush_pc = PCW'('h800);
        step();
        bus.flush        = 1'b0;
        bus.miss_ack     = 1'b1;
        bus.miss_next_pc = PCW'('h990);
        bus.tc_hit       = 1'b1;
        bus.tc_pc_next   = PCW'('h810);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.miss_req !== 1'b0) begin failures++; $display("[TB] FAIL flush_miss_req got %b want 0", bus.miss_req); end
        checks++; if (bus.tc_pc !== PCW'('h800)) begin failures++; $display("[TB] FAIL flush_tc_pc got %h want 800", bus.tc_pc); end
        step();
        bus.miss_ack = 1'b0;
        bus.tc_hit   = 1'b0;
        #1;
        checks++; if (bus.tc_pc !== PCW'('h810)) begin failures++; $display("[TB] FAIL flush_stale_ack got %h want 810", bus.tc_pc); end
        checks++; if (bus.out_pc !== PCW'('h800)) begin failures++; $display("[TB] FAIL flush_out_pc got %h want 800", bus.out_pc); end
        do_flush(PCW'('h1000));
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 12; c++) begin
            bus.tc_hit     = (c < 10);
            bus.tc_pc_next = PCW'('h1000 + 'h40 * (c + 1));
            bus.tc_valid   = mkmask(c);
            bus.tc_bundles = mkdata(c);
            bus.out_ready  = (c >= 2);
            #1;
            if (c < 10) begin
                checks++; if (bus.tc_pc_used !== 1'b1) begin failures++; $display("[TB] FAIL b2b_used[%0d] got %b want 1", c, bus.tc_pc_used); end
                checks++; if (bus.tc_pc !== PCW'('h1000 + 'h40 * c)) begin failures++; $display("[TB] FAIL b2b_tc_pc[%0d] got %h want %h", c, bus.tc_pc, PCW'('h1000 + 'h40 * c)); end
            end
            if (c >= 2) begin
                checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid[%0d] got %b want 1", c, bus.out_valid); end
                checks++; if (bus.out_pc !== PCW'('h1000 + 'h40 * (c - 2))) begin failures++; $display("[TB] FAIL b2b_out_pc[%0d] got %h want %h", c, bus.out_pc, PCW'('h1000 + 'h40 * (c - 2))); end
                checks++; if (bus.out_mask !== mkmask(c - 2)) begin failures++; $display("[TB] FAIL b2b_mask[%0d] got %h want %h", c, bus.out_mask, mkmask(c - 2)); end
                checks++; if (bus.out_data !== mkdata(c - 2)) begin failures++; $display("[TB] FAIL b2b_data[%0d] got %h want %h", c, bus.out_data[31:0], 32'(c - 2)); end
            end
            step();
        end
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_drained got %b want 0", bus.out_valid); end
        do_flush(PCW'('h600));
    endtask

    task automatic test_async_reset();
        bus.out_ready  = 1'b0;
        bus.tc_hit     = 1'b1;
        bus.tc_pc_next = PCW'('h610);
        step();
        bus.tc_pc_next = PCW'('h620);
        step();
        bus.tc_hit = 1'b0;
        step();
        #1;
        checks++; if (bus.miss_req !== 1'b1) begin failures++; $display("[TB] FAIL areset_pre_miss got %b want 1", bus.miss_req); end
        checks++; if (bus.tc_pc !== PCW'('h620)) begin failures++; $display("[TB] FAIL areset_pre_pc got %h want 620", bus.tc_pc); end
        bus.tc_hit = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL areset_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.miss_req !== 1'b0) begin failures++; $display("[TB] FAIL areset_miss_req got %b want 0", bus.miss_req); end
        checks++; if (bus.tc_pc_used !== 1'b0) begin failures++; $display("[TB] FAIL areset_used got %b want 0", bus.tc_pc_used); end
        checks++; if (bus.tc_pc !== PCW'(0)) begin failures++; $display("[TB] FAIL areset_tc_pc got %h want 0", bus.tc_pc); end
        step();
        bus.tc_hit = 1'b0;
        reset      = 1'b1;
        step();
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        reset            = 1'b0;
        bus.flush        = 1'b0;
        bus.flush_pc     = '0;
        bus.tc_hit       = 1'b1;
        bus.tc_valid     = '0;
        bus.tc_bundles   = '0;
        bus.tc_pc_next   = '0;
        bus.miss_ack     = 1'b0;
        bus.miss_next_pc = '0;
        bus.out_ready    = 1'b0;

        test_reset();
        test_first_hit();
        test_full();
        test_miss();
        test_flush();
        test_back_to_back();
        test_async_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
